multi_input_gate_checker: RTL and testbench

- Parametrised successor to the fixed 3-input checker.
- Sweeps all 2^N_IN input patterns onto an IC under test that has N_CH identical gates, with all gates driven in parallel.
- Compares each gate output against an internal reference gate chosen by gate_select, one pattern at a time, and reports per-channel and overall pass/fail.
- Sits between the IC-socket pin drivers and the result LEDs/status logic; starts on a start pulse instead of free-running.

---
 rtl/multi_input_gate_checker_if.sv | 42 ++++
 rtl/multi_input_gate_checker.sv | 207 ++++++++++++++++++++
 tb/tb_multi_input_gate_checker.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_input_gate_checker_if.sv
// rtl/multi_input_gate_checker_if.sv - socket pin and result bus for multi_input_gate_checker (FIRST_FAIL_CAPTURE_EN adds capture signals)
interface multi_input_gate_checker_if #(
  parameter int N_IN = 3,
  parameter int N_CH = 3
) ();
  logic            start;
  logic [2:0]      gate_select;
  logic [N_CH-1:0] dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic [N_CH-1:0] pass_ch;
  logic [N_CH-1:0] fail_ch;
  logic            pass;
  logic            fail;
  logic            sel_err;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_pattern;
  logic [2:0]      first_fail_ch;

  modport master (
    output start, gate_select, dut_out,
    input  dut_in, busy, done, pass_ch, fail_ch, pass, fail, sel_err,
    input  first_fail_valid, first_fail_pattern, first_fail_ch
  );
  modport slave (
    input  start, gate_select, dut_out,
    output dut_in, busy, done, pass_ch, fail_ch, pass, fail, sel_err,
    output first_fail_valid, first_fail_pattern, first_fail_ch
  );
`else
  modport master (
    output start, gate_select, dut_out,
    input  dut_in, busy, done, pass_ch, fail_ch, pass, fail, sel_err
  );
  modport slave (
    input  start, gate_select, dut_out,
    output dut_in, busy, done, pass_ch, fail_ch, pass, fail, sel_err
  );
`endif
endinterface

// File: rtl/multi_input_gate_checker.sv
// rtl/multi_input_gate_checker.sv - sweeps 2^N_IN patterns over N_CH gates and grades them (FIRST_FAIL_CAPTURE_EN adds first-fail capture)
module multi_input_gate_checker #(
  parameter int N_IN          = 3,
  parameter int N_CH          = 3,
  parameter int SETTLE_CYCLES = 50000000,
  parameter int CNT_W         = 32
) (
  input logic                       clk,
  input logic                       rst,
  multi_input_gate_checker_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  localparam logic [N_IN-1:0]  PAT_ONE  = 1;
  localparam logic [N_IN-1:0]  PAT_LAST = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [N_IN-1:0] pattern_q, pattern_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [N_CH-1:0] fail_mask_q, fail_mask_d;
  logic [N_CH-1:0] pass_ch_q, pass_ch_d;
  logic [N_CH-1:0] fail_ch_q, fail_ch_d;
  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            sel_err_q, sel_err_d;

  logic            expected;
  logic            sample;
  logic [N_CH-1:0] mismatch;
  logic [N_CH-1:0] final_mask;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic            ff_valid_q, ff_valid_d;
  logic [N_IN-1:0] ff_pattern_q, ff_pattern_d;
  logic [2:0]      ff_ch_q, ff_ch_d;
  logic [2:0]      lowest_ch;
`endif

  assign sample     = (state_q == S_APPLY) && (counter_q == CNT_LAST);
  assign mismatch   = sync2_q ^ {N_CH{expected}};
  assign final_mask = fail_mask_q | mismatch;

  // Reference gate response to the pattern currently on the socket
  always_comb begin
    case (sel_q)
      3'd0:    expected = &pattern_q;
      3'd1:    expected = |pattern_q;
      3'd2:    expected = ~&pattern_q;
      3'd3:    expected = ~|pattern_q;
      3'd4:    expected = ^pattern_q;
      3'd5:    expected = ~^pattern_q;
      default: expected = 1'b0;
    endcase
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // Lowest-index gate that disagrees with the reference this sample
  always_comb begin
    lowest_ch = 3'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mismatch[i]) lowest_ch = 3'(i);
    end
  end
`endif

  // Run sequencing, pattern stepping, compare accumulation and result latching
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pattern_d   = pattern_q;
    dut_in_d    = dut_in_q;
    counter_d   = counter_q;
    fail_mask_d = fail_mask_q;
    pass_ch_d   = pass_ch_q;
    fail_ch_d   = fail_ch_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    sel_err_d   = sel_err_q;
    sync1_d     = bus.dut_out;
    sync2_d     = sync1_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    ff_valid_d   = ff_valid_q;
    ff_pattern_d = ff_pattern_q;
    ff_ch_d      = ff_ch_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sel_d       = bus.gate_select;
          fail_mask_d = '0;
          pass_ch_d   = '0;
          fail_ch_d   = '0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          sel_err_d   = 1'b0;
          pattern_d   = '0;
          dut_in_d    = '0;
          counter_d   = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
          ff_valid_d   = 1'b0;
          ff_pattern_d = '0;
          ff_ch_d      = 3'd0;
`endif
          if (bus.gate_select > 3'd5) begin
            state_d   = S_DONE;
            fail_ch_d = '1;
            fail_d    = 1'b1;
            sel_err_d = 1'b1;
          end else begin
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        counter_d = counter_q + CNT_ONE;
        if (sample) begin
          fail_mask_d = final_mask;
          counter_d   = '0;
`ifdef FIRST_FAIL_CAPTURE_EN
          if (|mismatch && !ff_valid_q) begin
            ff_valid_d   = 1'b1;
            ff_pattern_d = pattern_q;
            ff_ch_d      = lowest_ch;
          end
`endif
          if (pattern_q == PAT_LAST) begin
            state_d   = S_DONE;
            fail_ch_d = final_mask;
            pass_ch_d = ~final_mask;
            pass_d    = ~|final_mask;
            fail_d    = |final_mask;
            dut_in_d  = '0;
          end else begin
            pattern_d = pattern_q + PAT_ONE;
            dut_in_d  = pattern_q + PAT_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 3'd0;
      pattern_q   <= '0;
      dut_in_q    <= '0;
      counter_q   <= '0;
      fail_mask_q <= '0;
      pass_ch_q   <= '0;
      fail_ch_q   <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_valid_q   <= 1'b0;
      ff_pattern_q <= '0;
      ff_ch_q      <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pattern_q   <= pattern_d;
      dut_in_q    <= dut_in_d;
      counter_q   <= counter_d;
      fail_mask_q <= fail_mask_d;
      pass_ch_q   <= pass_ch_d;
      fail_ch_q   <= fail_ch_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      sel_err_q   <= sel_err_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_valid_q   <= ff_valid_d;
      ff_pattern_q <= ff_pattern_d;
      ff_ch_q      <= ff_ch_d;
`endif
    end
  end

  assign bus.dut_in  = dut_in_q;
  assign bus.busy    = (state_q == S_APPLY);
  assign bus.done    = (state_q == S_DONE);
  assign bus.pass_ch = pass_ch_q;
  assign bus.fail_ch = fail_ch_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.sel_err = sel_err_q;
`ifdef FIRST_FAIL_CAPTURE_EN
  assign bus.first_fail_valid   = ff_valid_q;
  assign bus.first_fail_pattern = ff_pattern_q;
  assign bus.first_fail_ch      = ff_ch_q;
`endif

endmodule

// File: tb/tb_multi_input_gate_checker.sv
// tb/tb_multi_input_gate_checker.sv - directed bench with a run-level model for multi_input_gate_checker
module tb_multi_input_gate_checker;

  localparam int S     = 4;
  localparam int NA    = 3;
  localparam int CA    = 3;
  localparam int NB    = 2;
  localparam int CB    = 4;
  localparam int RUN_A = (1 << NA) * S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_input_gate_checker_if #(.N_IN(NA), .N_CH(CA)) ifa ();
  multi_input_gate_checker_if #(.N_IN(NB), .N_CH(CB)) ifb ();

  multi_input_gate_checker #(.N_IN(NA), .N_CH(CA), .SETTLE_CYCLES(S), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  multi_input_gate_checker #(.N_IN(NB), .N_CH(CB), .SETTLE_CYCLES(S), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gate truth from the count of ones in the pattern
  function automatic logic ref_fn(input int sel, input int p, input int n);
    int ones;
    ones = 0;
    for (int k = 0; k < n; k++) ones += (p >> k) & 1;
    case (sel)
      0: return ones == n;
      1: return ones != 0;
      2: return ones != n;
      3: return ones == 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Socket plant: 0 healthy, 1 stuck-at-0, 2 stuck-at-1, 3 wired as OR
  int ic_fn;
  int fault [CA];
  function automatic logic plant(input int fn, input int flt, input int p);
    case (flt)
      1: return 1'b0;
      2: return 1'b1;
      3: return ref_fn(1, p, NA);
      default: return ref_fn(fn, p, NA);
    endcase
  endfunction

  logic [CA-1:0] a_out;
  always_comb begin
    a_out = '0;
    for (int g = 0; g < CA; g++) a_out[g] = plant(ic_fn, fault[g], int'(ifa.dut_in));
  end
  assign ifa.dut_out = a_out;
  assign ifb.dut_out = {CB{ref_fn(2, int'(ifb.dut_in), NB)}};

  // Whole-run outcome predicted from the plant and the requested function
  logic [CA-1:0] c_mask;
  int c_ff_pat, c_ff_ch;
  always_comb begin
    c_mask   = '0;
    c_ff_pat = -1;
    c_ff_ch  = -1;
    for (int p = 0; p < (1 << NA); p++) begin
      for (int g = 0; g < CA; g++) begin
        if (plant(ic_fn, fault[g], p) != ref_fn(int'(ifa.gate_select), p, NA)) begin
          c_mask[g] = 1'b1;
          if (c_ff_pat < 0) begin
            c_ff_pat = p;
            c_ff_ch  = g;
          end
        end
      end
    end
  end

  // Run tracker: 0 idle, 1 legal run (done once RUN_A edges elapsed), 3 illegal select
  int cyc = 0;
  int m_t0 = 0;
  int m_state = 0;
  logic [CA-1:0] m_mask = '0;
  int m_ff_pat = -1;
  int m_ff_ch = -1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_state <= 0;
    end else if (ifa.start && !(m_state == 1 && (cyc - m_t0) < RUN_A)) begin
      m_t0     <= cyc + 1;
      m_state  <= (ifa.gate_select > 3'd5) ? 3 : 1;
      m_mask   <= c_mask;
      m_ff_pat <= c_ff_pat;
      m_ff_ch  <= c_ff_ch;
    end
  end

  int j;
  logic [NA-1:0] e_din;
  logic e_busy, e_done, e_pass, e_fail, e_serr, e_ffv;
  logic [CA-1:0] e_pch, e_fch;
  logic [NA-1:0] e_ffp;
  logic [2:0] e_ffc;
  always_comb begin
    e_din  = '0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_pass = 1'b0;
    e_fail = 1'b0;
    e_serr = 1'b0;
    e_pch  = '0;
    e_fch  = '0;
    e_ffv  = 1'b0;
    e_ffp  = '0;
    e_ffc  = 3'd0;
    j = cyc - m_t0;
    if (m_state == 3) begin
      e_done = 1'b1;
      e_fch  = '1;
      e_fail = 1'b1;
      e_serr = 1'b1;
    end else if (m_state == 1) begin
      if (j < RUN_A) begin
        e_busy = 1'b1;
        e_din  = NA'(j / S);
      end else begin
        e_done = 1'b1;
        e_fch  = m_mask;
        e_pch  = ~m_mask;
        e_pass = (m_mask == '0);
        e_fail = (m_mask != '0);
      end
      if (m_ff_pat >= 0 && j >= (m_ff_pat + 1) * S) begin
        e_ffv = 1'b1;
        e_ffp = NA'(m_ff_pat);
        e_ffc = 3'(m_ff_ch);
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_dut_in", ifa.dut_in, e_din);
      check("m_busy", ifa.busy, e_busy);
      check("m_done", ifa.done, e_done);
      check("m_pass_ch", ifa.pass_ch, e_pch);
      check("m_fail_ch", ifa.fail_ch, e_fch);
      check("m_pass", ifa.pass, e_pass);
      check("m_fail", ifa.fail, e_fail);
      check("m_sel_err", ifa.sel_err, e_serr);
`ifdef FIRST_FAIL_CAPTURE_EN
      check("m_ff_valid", ifa.first_fail_valid, e_ffv);
      check("m_ff_pattern", ifa.first_fail_pattern, e_ffp);
      check("m_ff_ch", ifa.first_fail_ch, e_ffc);
`endif
    end
  end

  task automatic pulse_a(input logic [2:0] sel);
    @(negedge clk);
    ifa.gate_select = sel;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input int lim);
    int k;
    k = 0;
    while (!ifa.done && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("wait_done", ifa.done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0;
    ifa.gate_select = 3'd0;
    ifb.start = 1'b0;
    ifb.gate_select = 3'd0;
    ic_fn = 0;
    for (int g = 0; g < CA; g++) fault[g] = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_done", ifa.done, 1'b0);
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_dut_in", ifa.dut_in, 3'd0);
    check("rst_b_done", ifb.done, 1'b0);

    // Healthy AND: exactly 32 cycles to done
    pulse_a(3'd0);
    check("t1_busy0", ifa.busy, 1'b1);
    repeat (RUN_A - 1) @(negedge clk);
    check("t1_done_early", ifa.done, 1'b0);
    @(negedge clk);
    check("t1_done", ifa.done, 1'b1);
    check("t1_pass_ch", ifa.pass_ch, 3'b111);
    check("t1_pass", ifa.pass, 1'b1);
    check("t1_fail", ifa.fail, 1'b0);

    // Gate 1 stuck-at-0
    fault[1] = 1;
    pulse_a(3'd0);
    wait_done_a(100);
    check("t2_fail_ch", ifa.fail_ch, 3'b010);
    check("t2_pass_ch", ifa.pass_ch, 3'b101);
    check("t2_pass", ifa.pass, 1'b0);
    check("t2_fail", ifa.fail, 1'b1);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("t2_ff_pattern", ifa.first_fail_pattern, 3'b111);
    check("t2_ff_ch", ifa.first_fail_ch, 3'd1);
`endif

    // XOR part with gate 2 behaving as OR
    fault[1] = 0;
    fault[2] = 3;
    ic_fn = 4;
    pulse_a(3'd4);
    repeat (13) @(negedge clk);
    check("t3_dut_in_j13", ifa.dut_in, 3'd3);
    wait_done_a(100);
    check("t3_fail_ch", ifa.fail_ch, 3'b100);
    check("t3_pass_ch", ifa.pass_ch, 3'b011);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("t3_ff_pattern", ifa.first_fail_pattern, 3'b011);
    check("t3_ff_ch", ifa.first_fail_ch, 3'd2);
`endif

    // Illegal select
    pulse_a(3'd7);
    check("t4_done", ifa.done, 1'b1);
    check("t4_sel_err", ifa.sel_err, 1'b1);
    check("t4_fail_ch", ifa.fail_ch, 3'b111);
    check("t4_pass_ch", ifa.pass_ch, 3'b000);
    check("t4_busy", ifa.busy, 1'b0);
    check("t4_dut_in", ifa.dut_in, 3'd0);

    // Reset mid-run at pattern 5, with start in the same cycle
    fault[2] = 0;
    ic_fn = 0;
    pulse_a(3'd0);
    repeat (20) @(negedge clk);
    check("t5_dut_in_5", ifa.dut_in, 3'b101);
    rst = 1'b1;
    ifa.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifa.start = 1'b0;
    check("t5_rst_busy", ifa.busy, 1'b0);
    check("t5_rst_done", ifa.done, 1'b0);
    check("t5_rst_dut_in", ifa.dut_in, 3'd0);
    check("t5_rst_fail", ifa.fail, 1'b0);
    pulse_a(3'd0);
    check("t5_restart_dut_in", ifa.dut_in, 3'd0);
    repeat (RUN_A - 1) @(negedge clk);
    check("t5_done_early", ifa.done, 1'b0);
    @(negedge clk);
    check("t5_done", ifa.done, 1'b1);
    check("t5_pass", ifa.pass, 1'b1);

    // Start and select change while busy are ignored
    pulse_a(3'd0);
    repeat (10) @(negedge clk);
    ifa.gate_select = 3'd1;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    check("t6_busy", ifa.busy, 1'b1);
    check("t6_dut_in", ifa.dut_in, 3'd2);
    wait_done_a(100);
    check("t6_pass_ch", ifa.pass_ch, 3'b111);
    check("t6_pass", ifa.pass, 1'b1);

    // Two-input, four-gate NAND part: 16 cycles
    @(negedge clk);
    ifb.gate_select = 3'd2;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    check("b_dut_in0", ifb.dut_in, 2'd0);
    repeat (12) @(negedge clk);
    check("b_dut_in3", ifb.dut_in, 2'd3);
    repeat (3) @(negedge clk);
    check("b_done_early", ifb.done, 1'b0);
    check("b_busy", ifb.busy, 1'b1);
    @(negedge clk);
    check("b_done", ifb.done, 1'b1);
    check("b_pass_ch", ifb.pass_ch, 4'b1111);
    check("b_fail_ch", ifb.fail_ch, 4'b0000);
    check("b_pass", ifb.pass, 1'b1);
    check("b_fail", ifb.fail, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
